pc_fetch_sequencer: RTL and testbench



---
 rtl/pc_fetch_sequencer_pkg.sv | 22 ++
 rtl/pc_fetch_sequencer_if.sv | 45 ++++
 rtl/pc_fetch_sequencer_redirect_sel.sv | 40 ++++
 rtl/pc_fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch_sequencer_pkg                                                     |
// | Shared address width, default vectors and fetch FSM state encoding.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pc_fetch_sequencer_pkg;

    localparam int INST_ADDR_W = 32;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0020;

    typedef enum logic [1:0] {
        PF_BOOT  = 2'd0,
        PF_FETCH = 2'd1,
        PF_WAIT  = 2'd2,
        PF_STALL = 2'd3
    } pf_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch_sequencer_if                                                      |
// | Redirect, stall, instruction-memory and IF/ID signals of the fetch stage.  |
// | Optional macro: PC_ALIGN_CHECK_EN adds misalign_o.                         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface pc_fetch_sequencer_if
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W
);
    logic              stall_i;
    logic              branch_i;
    logic [ADDR_W-1:0] branch_addr_i;
    logic              exc_i;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_ack_i;
    logic [ADDR_W-1:0] pc_o;
    logic [ADDR_W-1:0] pc_plus_4_o;
    logic              inst_valid_o;
    logic              flush_o;
`ifdef PC_ALIGN_CHECK_EN
    logic              misalign_o;
`endif

    modport master (
`ifdef PC_ALIGN_CHECK_EN
        output misalign_o,
`endif
        input  stall_i, branch_i, branch_addr_i, exc_i, imem_ack_i,
        output imem_req_o, imem_addr_o, pc_o, pc_plus_4_o, inst_valid_o, flush_o
    );

    modport slave (
`ifdef PC_ALIGN_CHECK_EN
        input  misalign_o,
`endif
        output stall_i, branch_i, branch_addr_i, exc_i, imem_ack_i,
        input  imem_req_o, imem_addr_o, pc_o, pc_plus_4_o, inst_valid_o, flush_o
    );

endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer_redirect_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_redirect_sel                                                            |
// | Next fetch address priority mux: exception > branch > pending > pc+4.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pc_redirect_sel
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W     = INST_ADDR_W,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
    input  logic              exc,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              pending_valid,
    input  logic [ADDR_W-1:0] pending_addr,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic [ADDR_W-1:0] next_addr,
    output logic              redirect
);

    // redirect flags only a fresh request this cycle; a pending target is
    // already known to the sequencer and needs no new latch.
    always_comb begin
        next_addr = fetch_pc + ADDR_W'(4);
        redirect  = 1'b0;
        if (exc) begin
            next_addr = EXC_VECTOR;
            redirect  = 1'b1;
        end else if (branch) begin
            next_addr = branch_addr;
            redirect  = 1'b1;
        end else if (pending_valid) begin
            next_addr = pending_addr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch_sequencer                                                         |
// | Fetch-stage PC sequencer with imem req/ack handshake, stalls, redirects.   |
// | Optional macro: PC_ALIGN_CHECK_EN (misaligned branch -> exception vector). |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W       = INST_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_fetch_sequencer_if.master bus
);

    pf_state_t         state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pending_addr;
    logic              pending_valid;
    logic              req;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus_4;
    logic              inst_valid;
    logic              flush;

    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] branch_target;
    logic              redirect;
    logic              exc_eff;

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_hit;
    logic misalign;

    assign misalign_hit   = bus.branch_i && (bus.branch_addr_i[1:0] != 2'b00);
    assign exc_eff        = bus.exc_i || misalign_hit;
    assign branch_target  = bus.branch_addr_i;
    assign bus.misalign_o = misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= misalign_hit;
        end
    end
`else
    assign exc_eff       = bus.exc_i;
    assign branch_target = bus.branch_addr_i & ~ADDR_W'(3);
`endif

    pc_redirect_sel #(
        .ADDR_W     (ADDR_W),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_redirect_sel (
        .exc           (exc_eff),
        .branch        (bus.branch_i),
        .branch_addr   (branch_target),
        .pending_valid (pending_valid),
        .pending_addr  (pending_addr),
        .fetch_pc      (fetch_pc),
        .next_addr     (next_addr),
        .redirect      (redirect)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= PF_BOOT;
            fetch_pc      <= RESET_VECTOR;
            pending_addr  <= RESET_VECTOR;
            pending_valid <= 1'b0;
            req           <= 1'b0;
            req_addr      <= RESET_VECTOR;
            pc            <= RESET_VECTOR;
            pc_plus_4     <= RESET_VECTOR + ADDR_W'(4);
            inst_valid    <= 1'b0;
            flush         <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            flush      <= 1'b0;
            case (state)
                PF_BOOT: begin
                    state    <= PF_FETCH;
                    req      <= 1'b1;
                    req_addr <= fetch_pc;
                end
                PF_FETCH, PF_STALL: begin
                    if (redirect) begin
                        // Nothing acked yet, so the in-progress request is simply retargeted.
                        state    <= PF_FETCH;
                        fetch_pc <= next_addr;
                        req      <= 1'b1;
                        req_addr <= next_addr;
                        flush    <= 1'b1;
                    end else if (bus.stall_i) begin
                        state <= PF_STALL;
                        req   <= 1'b0;
                    end else if (state == PF_STALL) begin
                        state    <= PF_FETCH;
                        req      <= 1'b1;
                        req_addr <= fetch_pc;
                    end else begin
                        state <= PF_WAIT;
                    end
                end
                PF_WAIT: begin
                    if (bus.imem_ack_i) begin
                        pending_valid <= 1'b0;
                        fetch_pc      <= next_addr;
                        req_addr      <= next_addr;
                        if (redirect || pending_valid) begin
                            // Wrong-path instruction: drop it and kill younger work.
                            state <= PF_FETCH;
                            req   <= 1'b1;
                            flush <= 1'b1;
                        end else begin
                            inst_valid <= 1'b1;
                            pc         <= fetch_pc;
                            pc_plus_4  <= fetch_pc + ADDR_W'(4);
                            state      <= bus.stall_i ? PF_STALL : PF_FETCH;
                            req        <= ~bus.stall_i;
                        end
                    end else if (redirect) begin
                        pending_valid <= 1'b1;
                        pending_addr  <= next_addr;
                    end
                end
                default: begin
                    state <= PF_BOOT;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req_o   = req;
    assign bus.imem_addr_o  = req_addr;
    assign bus.pc_o         = pc;
    assign bus.pc_plus_4_o  = pc_plus_4;
    assign bus.inst_valid_o = inst_valid;
    assign bus.flush_o      = flush;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_fetch_sequencer                                                      |
// | Directed bench with a delivered-PC scoreboard for pc_fetch_sequencer.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pc_fetch_sequencer;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] MIS_TARGET = 32'h0000_0020;
`else
    localparam logic [31:0] MIS_TARGET = 32'h0000_0100;
`endif

    logic clk;
    logic rst;
    int   passes;
    int   total;
    int   delivered;
    logic seen_300;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;

    pc_fetch_sequencer_if #(.ADDR_W(32)) bus ();

    pc_fetch_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Enter with the sequencer in FETCH presenting exp_addr; ack one cycle later.
    task automatic fetch_one(input logic [31:0] exp_addr);
        check_bit("fetch_req", bus.imem_req_o, 1'b1);
        check("fetch_addr", bus.imem_addr_o, exp_addr);
        step();
        check_bit("wait_req", bus.imem_req_o, 1'b1);
        check("wait_addr", bus.imem_addr_o, exp_addr);
        bus.imem_ack_i = 1'b1;
        exp_q.push_back(exp_addr);
        step();
        bus.imem_ack_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.inst_valid_o) begin
            check_bit("sb_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                sb_exp = exp_q.pop_front();
                check("sb_pc", bus.pc_o, sb_exp);
                check("sb_pc_plus_4", bus.pc_plus_4_o, sb_exp + 32'd4);
                delivered++;
            end
        end
        if (bus.imem_req_o && bus.imem_addr_o == 32'h0000_0300) seen_300 = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        passes            = 0;
        total             = 0;
        delivered         = 0;
        seen_300          = 1'b0;
        rst               = 1'b1;
        bus.stall_i       = 1'b0;
        bus.branch_i      = 1'b0;
        bus.branch_addr_i = 32'h0;
        bus.exc_i         = 1'b0;
        bus.imem_ack_i    = 1'b0;
        step();
        step();

        check_bit("rst_req", bus.imem_req_o, 1'b0);
        check("rst_addr", bus.imem_addr_o, 32'h0);
        check("rst_pc", bus.pc_o, 32'h0);
        check("rst_pc4", bus.pc_plus_4_o, 32'h4);
        check_bit("rst_valid", bus.inst_valid_o, 1'b0);
        check_bit("rst_flush", bus.flush_o, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        check_bit("rst_misalign", bus.misalign_o, 1'b0);
`endif

        rst = 1'b0;
        step();
        fetch_one(32'h0);
        fetch_one(32'h4);
        fetch_one(32'h8);

        // Branch while in FETCH
        check("pre_branch_addr", bus.imem_addr_o, 32'hC);
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'h100;
        step();
        bus.branch_i = 1'b0;
        check_bit("br_fetch_flush", bus.flush_o, 1'b1);
        check("br_fetch_addr", bus.imem_addr_o, 32'h100);
        fetch_one(32'h100);

        // Branch while in WAIT, ack three cycles later
        check("pre_wait_addr", bus.imem_addr_o, 32'h104);
        step();
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'h200;
        step();
        bus.branch_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_bit("pend_req_held", bus.imem_req_o, 1'b1);
            check("pend_addr_held", bus.imem_addr_o, 32'h104);
            check_bit("pend_no_flush", bus.flush_o, 1'b0);
            step();
        end
        check("pend_addr_held_last", bus.imem_addr_o, 32'h104);
        bus.imem_ack_i = 1'b1;
        step();
        bus.imem_ack_i = 1'b0;
        check_bit("pend_ack_flush", bus.flush_o, 1'b1);
        check_bit("pend_ack_invalid", bus.inst_valid_o, 1'b0);
        check("pend_next_addr", bus.imem_addr_o, 32'h200);
        fetch_one(32'h200);

        // Exception and branch in the same cycle
        bus.exc_i         = 1'b1;
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'h300;
        step();
        bus.exc_i    = 1'b0;
        bus.branch_i = 1'b0;
        check_bit("exc_flush", bus.flush_o, 1'b1);
        check("exc_addr", bus.imem_addr_o, 32'h20);
        fetch_one(32'h20);

        // Stall from FETCH for four cycles
        bus.stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_bit("stall_req", bus.imem_req_o, 1'b0);
            check("stall_pc", bus.pc_o, 32'h20);
        end
        bus.stall_i = 1'b0;
        step();
        fetch_one(32'h24);

        // Stall raised during WAIT: instruction still delivered
        step();
        bus.stall_i    = 1'b1;
        bus.imem_ack_i = 1'b1;
        exp_q.push_back(32'h28);
        step();
        bus.imem_ack_i = 1'b0;
        check_bit("wstall_valid", bus.inst_valid_o, 1'b1);
        check_bit("wstall_req", bus.imem_req_o, 1'b0);
        bus.stall_i = 1'b0;
        step();
        check_bit("wstall_resume_req", bus.imem_req_o, 1'b1);
        check("wstall_resume_addr", bus.imem_addr_o, 32'h2C);

        // Address wrap at the top of the space
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'hFFFF_FFFC;
        step();
        bus.branch_i = 1'b0;
        fetch_one(32'hFFFF_FFFC);
        check("wrap_addr", bus.imem_addr_o, 32'h0);

        // Misaligned branch target
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'h102;
        step();
        bus.branch_i = 1'b0;
        check_bit("mis_flush", bus.flush_o, 1'b1);
        check("mis_addr", bus.imem_addr_o, MIS_TARGET);
`ifdef PC_ALIGN_CHECK_EN
        check_bit("mis_pulse", bus.misalign_o, 1'b1);
`endif
        fetch_one(MIS_TARGET);
`ifdef PC_ALIGN_CHECK_EN
        check_bit("mis_pulse_end", bus.misalign_o, 1'b0);
`endif

        // Reset during WAIT; late ack must be ignored
        step();
        rst = 1'b1;
        step();
        check_bit("mid_rst_req", bus.imem_req_o, 1'b0);
        check("mid_rst_addr", bus.imem_addr_o, 32'h0);
        check("mid_rst_pc", bus.pc_o, 32'h0);
        rst            = 1'b0;
        bus.imem_ack_i = 1'b1;
        step();
        bus.imem_ack_i = 1'b0;
        check_bit("late_ack_invalid", bus.inst_valid_o, 1'b0);
        fetch_one(32'h0);
        step();
        step();

        check("sb_empty", exp_q.size(), 32'd0);
        check("sb_delivered", delivered, 32'd11);
        check_bit("never_req_300", seen_300, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
